// File: rtl/wb_exc_commit_pkg.sv
// wb_exc_commit_pkg
//   Shared constants for the write-back / exception commit stage:
//   MIPS exception codes, the general exception vector, the CP0
//   register addresses ({rd,sel}) and the packed WB payload record.
package wb_exc_commit_pkg;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } excode_e;

    localparam logic [31:0] EXC_VECTOR = 32'hbfc0_0380;

    // CP0 register addresses, {rd[4:0], sel[2:0]}
    localparam logic [7:0] CR_BADVADDR = 8'h40;
    localparam logic [7:0] CR_COUNT    = 8'h48;
    localparam logic [7:0] CR_COMPARE  = 8'h58;
    localparam logic [7:0] CR_STATUS   = 8'h60;
    localparam logic [7:0] CR_CAUSE    = 8'h68;
    localparam logic [7:0] CR_EPC      = 8'h70;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] badvaddr;
        logic [4:0]  excode;
        logic [7:0]  c0_addr;
        logic [4:0]  dest;
        logic        ex;
        logic        bd;
        logic        eret;
        logic        mtc0;
        logic        mfc0;
        logic        rf_we;
    } ws_payload_t;

endpackage

// File: rtl/wb_exc_commit.sv
// wb_exc_commit
//   Single-entry write-back stage that commits one instruction per cycle
//   and resolves exceptions, interrupts and eret toward CP0 and the
//   pipeline front end.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   ms_to_ws_valid / ws_allowin MEM->WB handshake
//   ms_*                        MEM payload (pc, result, badvaddr, flags,
//                               excode, c0_addr, dest)
//   has_int, c0_epc, c0_rdata   CP0 status inputs
//   mtc0_we, wb_ex, wb_bd,      CP0 commit strobes and exception info
//   eret_flush, c0_raddr,
//   c0_wdata, wb_pc,
//   wb_badvaddr, wb_excode
//   rf_we, rf_waddr, rf_wdata   GPR write port
//   flush, flush_pc             pipeline flush and redirect target
//   ws_ex_block                 WB holds an exception/eret/interrupt
module wb_exc_commit
    import wb_exc_commit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [31:0] ms_result,
    input  logic [31:0] ms_badvaddr,
    input  logic        ms_ex,
    input  logic        ms_bd,
    input  logic        ms_eret,
    input  logic        ms_mtc0,
    input  logic        ms_mfc0,
    input  logic        ms_rf_we,
    input  logic [4:0]  ms_excode,
    input  logic [7:0]  ms_c0_addr,
    input  logic [4:0]  ms_dest,

    input  logic        has_int,
    input  logic [31:0] c0_epc,
    input  logic [31:0] c0_rdata,

    output logic        mtc0_we,
    output logic        wb_ex,
    output logic        wb_bd,
    output logic        eret_flush,
    output logic [7:0]  c0_raddr,
    output logic [31:0] c0_wdata,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_badvaddr,
    output logic [4:0]  wb_excode,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        ws_ex_block
);

    logic        ws_valid;
    ws_payload_t ws;
    logic        eff_int;
    logic        eff_ex;
    logic        ws_take;

    // WB always completes in one cycle, so the only stall is the flush cycle,
    // which also discards whatever MEM is offering.
    assign ws_allowin = !flush;
    assign ws_take    = ws_allowin && ms_to_ws_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
            ws       <= '0;
        end else begin
            ws_valid <= ws_take;
            if (ws_take) begin
                ws <= '{pc:       ms_pc,
                        result:   ms_result,
                        badvaddr: ms_badvaddr,
                        excode:   ms_excode,
                        c0_addr:  ms_c0_addr,
                        dest:     ms_dest,
                        ex:       ms_ex,
                        bd:       ms_bd,
                        eret:     ms_eret,
                        mtc0:     ms_mtc0,
                        mfc0:     ms_mfc0,
                        rf_we:    ms_rf_we};
            end
        end
    end

    // An interrupt is attached to whatever instruction is committing; with
    // WB empty it simply waits for the next valid instruction.
    assign eff_int = ws_valid && has_int;
    assign eff_ex  = ws_valid && (ws.ex || has_int);

    always_comb begin
        wb_ex       = eff_ex;
        eret_flush  = ws_valid && ws.eret && !eff_ex;
        wb_excode   = eff_int ? EXC_INT : ws.excode;
        wb_pc       = ws.pc;
        wb_bd       = ws.bd;
        wb_badvaddr = ws.badvaddr;

        mtc0_we     = ws_valid && ws.mtc0 && !eff_ex;
        c0_wdata    = ws.result;
        c0_raddr    = ws.c0_addr;

        rf_we       = ws_valid && ws.rf_we && !eff_ex;
        rf_waddr    = ws.dest;
        rf_wdata    = ws.mfc0 ? c0_rdata : ws.result;

        flush       = wb_ex || eret_flush;
        flush_pc    = '0;
        if (wb_ex) begin
            flush_pc = EXC_VECTOR;
        end else if (eret_flush) begin
            flush_pc = c0_epc;
        end

        ws_ex_block = ws_valid && (ws.ex || ws.eret || has_int);
    end

endmodule

// File: tb/tb_wb_exc_commit.sv
module tb_wb_exc_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc, ms_result, ms_badvaddr;
    logic        ms_ex, ms_bd, ms_eret, ms_mtc0, ms_mfc0, ms_rf_we;
    logic [4:0]  ms_excode;
    logic [7:0]  ms_c0_addr;
    logic [4:0]  ms_dest;
    logic        has_int;
    logic [31:0] c0_epc, c0_rdata;
    logic        mtc0_we, wb_ex, wb_bd, eret_flush;
    logic [7:0]  c0_raddr;
    logic [31:0] c0_wdata, wb_pc, wb_badvaddr;
    logic [4:0]  wb_excode;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ws_ex_block;

    always #5 clk = ~clk;

    wb_exc_commit dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_badvaddr(ms_badvaddr),
        .ms_ex(ms_ex), .ms_bd(ms_bd), .ms_eret(ms_eret), .ms_mtc0(ms_mtc0),
        .ms_mfc0(ms_mfc0), .ms_rf_we(ms_rf_we), .ms_excode(ms_excode),
        .ms_c0_addr(ms_c0_addr), .ms_dest(ms_dest),
        .has_int(has_int), .c0_epc(c0_epc), .c0_rdata(c0_rdata),
        .mtc0_we(mtc0_we), .wb_ex(wb_ex), .wb_bd(wb_bd), .eret_flush(eret_flush),
        .c0_raddr(c0_raddr), .c0_wdata(c0_wdata), .wb_pc(wb_pc),
        .wb_badvaddr(wb_badvaddr), .wb_excode(wb_excode),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush(flush), .flush_pc(flush_pc), .ws_ex_block(ws_ex_block)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc, result, badvaddr;
        logic        ex, bd, eret, mtc0, mfc0, rf_we;
        logic [4:0]  excode;
        logic [7:0]  c0_addr;
        logic [4:0]  dest;
    } instr_t;

    typedef enum { K_IDLE, K_INT, K_EXC, K_ERET, K_OK } kind_e;

    // Reference state: the instruction the stage should be holding.
    instr_t      held;
    logic        held_valid;
    // Stimulus for the current cycle.
    instr_t      drv;
    logic        d_reset, d_int;
    logic [31:0] d_epc, d_rdata;
    logic        exp_flush;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t bubble();
        instr_t r;
        r = '{default: '0};
        return r;
    endfunction

    // Drive this cycle's inputs on the falling edge and compare every output
    // with what the held instruction and the CP0 inputs imply.
    task automatic drive_and_check();
        kind_e       k;
        logic        e_ex, e_eret;
        logic [31:0] e_fpc;
        @(negedge clk);
        reset          = d_reset;
        ms_to_ws_valid = drv.valid;
        ms_pc = drv.pc; ms_result = drv.result; ms_badvaddr = drv.badvaddr;
        ms_ex = drv.ex; ms_bd = drv.bd; ms_eret = drv.eret; ms_mtc0 = drv.mtc0;
        ms_mfc0 = drv.mfc0; ms_rf_we = drv.rf_we; ms_excode = drv.excode;
        ms_c0_addr = drv.c0_addr; ms_dest = drv.dest;
        has_int = d_int; c0_epc = d_epc; c0_rdata = d_rdata;
        #1;
        if (!held_valid)   k = K_IDLE;
        else if (d_int)    k = K_INT;
        else if (held.ex)  k = K_EXC;
        else if (held.eret) k = K_ERET;
        else               k = K_OK;
        e_ex      = (k == K_INT) || (k == K_EXC);
        e_eret    = (k == K_ERET);
        exp_flush = e_ex || e_eret;
        e_fpc     = e_ex ? 32'hbfc0_0380 : (e_eret ? d_epc : 32'h0);
        check("wb_ex",       {31'd0, wb_ex},       {31'd0, e_ex});
        check("eret_flush",  {31'd0, eret_flush},  {31'd0, e_eret});
        check("flush",       {31'd0, flush},       {31'd0, exp_flush});
        check("flush_pc",    flush_pc,             e_fpc);
        check("ws_allowin",  {31'd0, ws_allowin},  {31'd0, !exp_flush});
        check("wb_excode",   {27'd0, wb_excode},   {27'd0, (k == K_INT) ? 5'h00 : held.excode});
        check("wb_pc",       wb_pc,                held.pc);
        check("wb_bd",       {31'd0, wb_bd},       {31'd0, held.bd});
        check("wb_badvaddr", wb_badvaddr,          held.badvaddr);
        check("mtc0_we",     {31'd0, mtc0_we},     {31'd0, (k == K_OK || k == K_ERET) && held.mtc0});
        check("c0_wdata",    c0_wdata,             held.result);
        check("c0_raddr",    {24'd0, c0_raddr},    {24'd0, held.c0_addr});
        check("rf_we",       {31'd0, rf_we},       {31'd0, (k == K_OK || k == K_ERET) && held.rf_we});
        check("rf_waddr",    {27'd0, rf_waddr},    {27'd0, held.dest});
        check("rf_wdata",    rf_wdata,             held.mfc0 ? d_rdata : held.result);
        check("ws_ex_block", {31'd0, ws_ex_block},
              {31'd0, held_valid && (held.ex || held.eret || d_int)});
    endtask

    task automatic advance();
        @(posedge clk);
        if (d_reset) begin
            held       = bubble();
            held_valid = 1'b0;
        end else if (drv.valid && !exp_flush) begin
            held       = drv;
            held_valid = 1'b1;
        end else begin
            held_valid = 1'b0;
        end
    endtask

    task automatic step();
        drive_and_check();
        advance();
    endtask

    initial begin
        held = bubble(); held_valid = 1'b0;
        drv = bubble(); d_reset = 1'b1; d_int = 1'b0; d_epc = '0; d_rdata = '0;
        exp_flush = 1'b0;
        reset = 1'b1; ms_to_ws_valid = 1'b0; has_int = 1'b0; c0_epc = '0; c0_rdata = '0;
        ms_pc = '0; ms_result = '0; ms_badvaddr = '0; ms_ex = 0; ms_bd = 0; ms_eret = 0;
        ms_mtc0 = 0; ms_mfc0 = 0; ms_rf_we = 0; ms_excode = '0; ms_c0_addr = '0; ms_dest = '0;
        repeat (2) @(posedge clk);

        // reset state
        step();
        d_reset = 1'b0;
        drive_and_check();
        check("rst_allowin", {31'd0, ws_allowin}, 32'd1);
        check("rst_fpc", flush_pc, 32'h0);
        advance();

        // plain ALU
        drv = bubble(); drv.valid = 1; drv.pc = 32'hbfc0_0010; drv.rf_we = 1;
        drv.dest = 5'd5; drv.result = 32'h1234;
        step();
        drv = bubble();
        drive_and_check();
        check("alu_rf_we", {31'd0, rf_we}, 32'd1);
        check("alu_waddr", {27'd0, rf_waddr}, 32'd5);
        check("alu_wdata", rf_wdata, 32'h1234);
        check("alu_flush", {31'd0, flush}, 32'd0);
        advance();

        // syscall in a delay slot; the following instruction is dropped
        drv = bubble(); drv.valid = 1; drv.ex = 1; drv.excode = 5'h08; drv.bd = 1;
        drv.pc = 32'hbfc0_0020; drv.rf_we = 1; drv.dest = 5'd9;
        step();
        drv = bubble(); drv.valid = 1; drv.rf_we = 1; drv.dest = 5'd3; drv.result = 32'hdead;
        drive_and_check();
        check("sys_wb_ex", {31'd0, wb_ex}, 32'd1);
        check("sys_bd", {31'd0, wb_bd}, 32'd1);
        check("sys_pc", wb_pc, 32'hbfc0_0020);
        check("sys_fpc", flush_pc, 32'hbfc0_0380);
        check("sys_rf_we", {31'd0, rf_we}, 32'd0);
        check("sys_excode", {27'd0, wb_excode}, 32'h08);
        advance();
        drv = bubble();
        drive_and_check();
        check("sys_dropped", {31'd0, rf_we}, 32'd0);
        advance();

        // eret
        drv = bubble(); drv.valid = 1; drv.eret = 1;
        step();
        drv = bubble(); d_epc = 32'hbfc0_0100;
        drive_and_check();
        check("eret_flush", {31'd0, eret_flush}, 32'd1);
        check("eret_fpc", flush_pc, 32'hbfc0_0100);
        check("eret_wb_ex", {31'd0, wb_ex}, 32'd0);
        advance();

        // interrupt wins over mtc0
        drv = bubble(); drv.valid = 1; drv.mtc0 = 1; drv.c0_addr = 8'h60; drv.result = 32'h1;
        step();
        drv = bubble(); d_int = 1'b1;
        drive_and_check();
        check("int_wb_ex", {31'd0, wb_ex}, 32'd1);
        check("int_excode", {27'd0, wb_excode}, 32'h00);
        check("int_mtc0", {31'd0, mtc0_we}, 32'd0);
        advance();
        // interrupt with WB empty does nothing
        drive_and_check();
        check("int_idle", {31'd0, flush}, 32'd0);
        advance();
        d_int = 1'b0;

        // address error
        drv = bubble(); drv.valid = 1; drv.ex = 1; drv.excode = 5'h04; drv.badvaddr = 32'h3;
        step();
        drv = bubble();
        drive_and_check();
        check("adel_bva", wb_badvaddr, 32'h3);
        check("adel_flush", {31'd0, flush}, 32'd1);
        advance();

        // mfc0, then reset on its commit cycle
        drv = bubble(); drv.valid = 1; drv.mfc0 = 1; drv.rf_we = 1; drv.c0_addr = 8'h60;
        drv.dest = 5'd7;
        step();
        drv = bubble(); drv.valid = 1; drv.rf_we = 1; drv.result = 32'h55;
        d_rdata = 32'h0040_ff01; d_reset = 1'b1;
        drive_and_check();
        check("mfc0_raddr", {24'd0, c0_raddr}, 32'h60);
        check("mfc0_wdata", rf_wdata, 32'h0040_ff01);
        advance();
        d_reset = 1'b0; drv = bubble();
        drive_and_check();
        check("post_rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("post_rst_wdata", rf_wdata, 32'h0);
        check("post_rst_raddr", {24'd0, c0_raddr}, 32'h0);
        check("post_rst_allowin", {31'd0, ws_allowin}, 32'd1);
        advance();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drv.valid    = ($urandom_range(0, 3) != 0);
            drv.pc       = $urandom; drv.result = $urandom; drv.badvaddr = $urandom;
            drv.ex       = ($urandom_range(0, 4) == 0);
            drv.bd       = $urandom_range(0, 1);
            drv.eret     = ($urandom_range(0, 6) == 0);
            drv.mtc0     = $urandom_range(0, 1);
            drv.mfc0     = $urandom_range(0, 1);
            drv.rf_we    = $urandom_range(0, 1);
            drv.excode   = 5'($urandom);
            drv.c0_addr  = 8'($urandom);
            drv.dest     = 5'($urandom);
            d_int        = ($urandom_range(0, 7) == 0);
            d_reset      = ($urandom_range(0, 39) == 0);
            d_epc        = $urandom;
            d_rdata      = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
